// File: rtl/motor_dispenser.sv
// Three-channel stepper dispenser: loads per-colour step budgets on a trigger
// edge, then paces step pulses on the selected channel through a prescaler.
module motor_dispenser #(
  parameter logic [15:0] PRESCALE       = 16'd50000,
  parameter logic [7:0]  STEPS_PER_UNIT = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [2:0] Motores,
  input  logic [7:0] r_val,
  input  logic [7:0] g_val,
  input  logic [7:0] b_val,
  output logic [2:0] step,
  output logic [2:0] flags,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    FAULT
  } state_t;

  localparam logic [15:0] LP_LAST = PRESCALE - 16'd1;

  logic             r_trig_d;
  logic [2:0]       r_sel_d;
  logic [15:0]      r_presc;
  logic [2:0][15:0] r_rem;
  logic [2:0]       r_step;
  logic [2:0]       r_flags;
  logic             r_busy;
  logic             r_err;

  logic        w_load;
  logic        w_onehot;
  logic        w_chg;
  logic        w_tick;
  logic [1:0]  w_idx;
  logic [15:0] w_cur;
  state_t      w_state;

  always_comb begin
    w_load   = trigger & ~r_trig_d;
    w_onehot = $onehot(Motores);
    // direct hop between two legal channels restarts pacing
    w_chg    = $onehot(r_sel_d) && w_onehot
               && (r_sel_d != Motores);
    w_tick   = (r_presc == LP_LAST);
    w_idx    = 2'd0;
    case (Motores)
      3'b100:  w_idx = 2'd2;
      3'b010:  w_idx = 2'd1;
      default: w_idx = 2'd0;
    endcase
    w_cur = r_rem[w_idx];
    if (Motores == 3'b000)
      w_state = IDLE;
    else if (!w_onehot)
      w_state = FAULT;
    else if (w_cur == 16'd0)
      w_state = HOLD;
    else
      w_state = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trig_d <= 1'b0;
      r_sel_d  <= 3'b000;
      r_presc  <= 16'd0;
      r_rem    <= '0;
      r_step   <= 3'b000;
      r_flags  <= 3'b000;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_trig_d <= trigger;
      r_sel_d  <= Motores;
      r_step   <= 3'b000;
      r_err    <= (w_state == FAULT);
      unique case (w_state)
        IDLE: begin
          r_flags <= 3'b000;
          r_presc <= 16'd0;
          r_busy  <= 1'b0;
        end
        FAULT: begin
          r_presc <= 16'd0;
          r_busy  <= 1'b0;
        end
        HOLD: begin
          if (!w_load)
            r_flags[w_idx] <= 1'b1;
          r_presc <= 16'd0;
          r_busy  <= 1'b0;
        end
        RUN: begin
          r_busy <= 1'b1;
          if (w_chg) begin
            r_presc <= 16'd0;
          end else if (w_tick) begin
            r_presc        <= 16'd0;
            r_step[w_idx]  <= 1'b1;
            r_rem[w_idx]   <= w_cur - 16'd1;
          end else begin
            r_presc <= r_presc + 16'd1;
          end
        end
        default: begin
          r_presc <= 16'd0;
          r_busy  <= 1'b0;
        end
      endcase
      // a fresh load wins over anything the channel logic did this cycle
      if (w_load) begin
        r_rem[2] <= {8'd0, r_val} * {8'd0, STEPS_PER_UNIT};
        r_rem[1] <= {8'd0, g_val} * {8'd0, STEPS_PER_UNIT};
        r_rem[0] <= {8'd0, b_val} * {8'd0, STEPS_PER_UNIT};
        r_presc  <= 16'd0;
        r_step   <= 3'b000;
        r_busy   <= 1'b0;
      end
    end
  end

  assign step  = r_step;
  assign flags = r_flags;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule

// File: tb/tb_motor_dispenser.sv
// Bench for motor_dispenser at PRESCALE=4, STEPS_PER_UNIT=2:
// vector table through a scoreboard queue plus a held-trigger sequence.
module tb_motor_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic [2:0] Motores = 3'b000;
  logic [7:0] r_val = 8'd0;
  logic [7:0] g_val = 8'd0;
  logic [7:0] b_val = 8'd0;
  logic [2:0] step;
  logic [2:0] flags;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;

  motor_dispenser #(
    .PRESCALE      (16'd4),
    .STEPS_PER_UNIT(8'd2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .trigger(trigger),
    .Motores(Motores),
    .r_val  (r_val),
    .g_val  (g_val),
    .b_val  (b_val),
    .step   (step),
    .flags  (flags),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       trg;
    logic [2:0] m;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [2:0] st;
    logic [2:0] fl;
    logic       bz;
    logic       er;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] o;
  } exp_t;

  vec_t tv[$];
  exp_t sbq[$];

  function automatic vec_t mk(
    input logic       rst,
    input logic       trg,
    input logic [2:0] m,
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b,
    input logic [2:0] st,
    input logic [2:0] fl,
    input logic       bz,
    input logic       er
  );
    vec_t v;
    v.rst = rst; v.trg = trg; v.m = m;
    v.r = r; v.g = g; v.b = b;
    v.st = st; v.fl = fl; v.bz = bz; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    exp_t       e;
    logic [7:0] got;
    int         cnt;
    int         done;
    int         dbl;
    logic       prev;

    // reset, then r=1 load with R selected together
    tv.push_back(mk(1,0,3'b000,0,0,0, 3'b000,3'b000,0,0));
    tv.push_back(mk(0,1,3'b100,1,0,1, 3'b000,3'b000,0,0));
    tv.push_back(mk(0,1,3'b100,1,0,1, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,1,0,1, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,1,0,1, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,1,0,1, 3'b100,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,5,0,1, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,5,0,1, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,5,0,1, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,5,0,1, 3'b100,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,5,0,1, 3'b000,3'b100,0,0));
    tv.push_back(mk(0,1,3'b100,5,0,1, 3'b000,3'b100,0,0));
    // zero-amount G, then B with two steps
    tv.push_back(mk(0,0,3'b010,5,0,1, 3'b000,3'b110,0,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b000,3'b110,1,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b000,3'b110,1,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b000,3'b110,1,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b000,3'b110,1,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b001,3'b110,1,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b000,3'b110,1,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b000,3'b110,1,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b000,3'b110,1,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b001,3'b110,1,0));
    tv.push_back(mk(0,0,3'b001,5,0,1, 3'b000,3'b111,0,0));
    tv.push_back(mk(0,0,3'b000,5,0,1, 3'b000,3'b000,0,0));
    // r=2 load, fault in mid-run, resume, idle, resume
    tv.push_back(mk(0,1,3'b100,2,0,0, 3'b000,3'b000,0,0));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,0,3'b110,2,0,0, 3'b000,3'b000,0,1));
    tv.push_back(mk(0,0,3'b110,2,0,0, 3'b000,3'b000,0,1));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b100,3'b000,1,0));
    tv.push_back(mk(0,0,3'b000,2,0,0, 3'b000,3'b000,0,0));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,0,3'b100,2,0,0, 3'b100,3'b000,1,0));
    // trigger through reset release, then reset before the 2nd step
    tv.push_back(mk(1,1,3'b100,1,0,0, 3'b000,3'b000,0,0));
    tv.push_back(mk(0,1,3'b100,1,0,0, 3'b000,3'b000,0,0));
    tv.push_back(mk(0,1,3'b100,1,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,1,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,1,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,1,0,0, 3'b100,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,1,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,1,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(0,1,3'b100,1,0,0, 3'b000,3'b000,1,0));
    tv.push_back(mk(1,1,3'b100,1,0,0, 3'b000,3'b000,0,0));
    tv.push_back(mk(0,0,3'b100,1,0,0, 3'b000,3'b100,0,0));
    tv.push_back(mk(0,0,3'b100,1,0,0, 3'b000,3'b100,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      reset   = tv[i].rst;
      trigger = tv[i].trg;
      Motores = tv[i].m;
      r_val   = tv[i].r;
      g_val   = tv[i].g;
      b_val   = tv[i].b;
      sbq.push_back('{i, {tv[i].st, tv[i].fl, tv[i].bz, tv[i].er}});
      @(posedge clk);
      #1;
      e   = sbq.pop_front();
      got = {step, flags, busy, err};
      checks++;
      if (got !== e.o) begin
        failures++;
        $display("FAIL vec%0d got step=%b flags=%b busy=%b err=%b exp step=%b flags=%b busy=%b err=%b",
                 e.idx, got[7:5], got[4:2], got[1], got[0],
                 e.o[7:5], e.o[4:2], e.o[1], e.o[0]);
      end
    end

    // held trigger: only the value on the rising cycle counts
    @(negedge clk);
    reset = 1'b1; trigger = 1'b0; Motores = 3'b000;
    @(negedge clk);
    reset = 1'b0; trigger = 1'b1; r_val = 8'd3;
    @(negedge clk);
    r_val = 8'd9;
    repeat (19) @(negedge clk);
    trigger = 1'b0;
    Motores = 3'b100;
    cnt = 0; done = 0; dbl = 0; prev = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (step[2]) begin
        cnt++;
        if (prev) dbl++;
      end
      prev = step[2];
      if (flags[2]) begin
        done = 1;
        break;
      end
    end
    chk("held_trig_done", done, 1);
    chk("held_trig_steps", cnt, 6);
    chk("pulse_width", dbl, 0);
    chk("held_busy_low", int'(busy), 0);
    chk("held_err_low", int'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_dispenser.md
MOTOR_DISPENSER -- requirements
Module: motor_dispenser

Interface
REQ-001 Parameter PRESCALE, default 16'd50000, clock cycles per motor step (legal range 2..65535).
REQ-002 Parameter STEPS_PER_UNIT, default 8'd4, motor steps dispensed per unit of colour value.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 trigger  input  1  load request from the sequencing FSM; sampled every cycle.
REQ-006 Motores  input  3  motor select; bit2=R, bit1=Y/G, bit0=B; one-hot or 000.
REQ-007 r_val, g_val, b_val  input  8 each  colour amounts, sampled only on load.
REQ-008 step  output  3  one-cycle step pulse per channel, same bit order as Motores.
REQ-009 flags  output  3  per-channel done; bit2=R, bit1=G, bit0=B.
REQ-010 busy  output  1  high while the selected channel has steps remaining.
REQ-011 err  output  1  high in the cycle after an illegal Motores code is sampled.

Function
REQ-012 Load event = trigger==1 and registered trigger_d==0; the block SHALL load rem_r/rem_g/rem_b (16-bit) with r_val*STEPS_PER_UNIT, g_val*STEPS_PER_UNIT and b_val*STEPS_PER_UNIT, without overflow.
REQ-013 trigger held high across many cycles SHALL cause exactly one load.
REQ-014 On a load cycle, prescaler SHALL clear to 0, no step SHALL be issued and no rem SHALL decrement; the load overrides any decrement in the same cycle.
REQ-015 States: IDLE (Motores==000), RUN (legal one-hot Motores, rem[ch]!=0), HOLD (legal one-hot Motores, rem[ch]==0), FAULT (Motores has more than one bit set).
REQ-016 IDLE: flags<=000, prescaler<=0, step<=000, busy<=0; rem values retained.
REQ-017 RUN: prescaler increments each cycle; when prescaler==PRESCALE-1 it wraps to 0, step[ch]<=1 for exactly one cycle and rem[ch]<=rem[ch]-1; other step bits stay 0; busy<=1.
REQ-018 RUN->HOLD when rem[ch] reaches 0; in HOLD flags[ch]<=1, busy<=0, prescaler held at 0, no steps.
REQ-019 flags[ch] SHALL stay high until Motores returns to 000 or reset; flags of other channels SHALL NOT change while a channel is selected.
REQ-020 A change from one one-hot code directly to another SHALL clear the prescaler and start the new channel; flags already set are kept.
REQ-021 A zero amount (rem[ch]==0 when selected) SHALL set flags[ch] on the first clock edge after selection, with no step pulses.
REQ-022 FAULT: step<=000, busy<=0, prescaler<=0, err<=1, flags and rem unchanged; err clears on the first legal code.
REQ-023 rem SHALL never decrement below 0; no wrap-around.
REQ-024 All outputs SHALL be registered; step pulse width is exactly 1 clk.

Reset
REQ-025 Synchronous reset SHALL set step=000, flags=000, busy=0, err=0, rem_*=0, prescaler=0, trigger_d=0, state IDLE.
REQ-026 Reset mid-RUN SHALL abort immediately; no further steps until a new load event and selection.
REQ-027 A trigger held high through reset release SHALL produce a load on the first post-reset cycle, because trigger_d==0 after reset.

Verification (PRESCALE=4, STEPS_PER_UNIT=2)
REQ-028 r_val=1, trigger and Motores=100 rise together at edge 0 -> step[2] high after edges 4 and 8; flags[2]=1 after edge 9; busy=0 from edge 9.
REQ-029 g_val=0, Motores=010 after load -> flags[1]=1 one edge after selection, step stays 000.
REQ-030 flags=111, then Motores=000 for one cycle -> flags=000 next cycle; rem retained.
REQ-031 Motores=110 during RUN -> err=1 next cycle, step=000, rem unchanged; Motores back to 100 -> err=0, stepping resumes with the prescaler from 0.
REQ-032 reset asserted one cycle before the 2nd step of r_val=1 -> no 2nd pulse, all outputs 0, rem_r=0.
REQ-033 trigger held high 20 cycles with r_val changing mid-pulse -> rem_r reflects only the value sampled on the rising-edge cycle.
